// File: rtl/osc_cal_ctrl.sv
// rtl/osc_cal_ctrl.sv - ring oscillator coarse/fine delay calibration controller
// Steps thermometer delay codes until the tick count per window meets TARGET.
module osc_cal_ctrl #(
  parameter int WIN_LEN    = 256,
  parameter int SETTLE_LEN = 16,
  parameter int TARGET     = 128,
  parameter int TOL        = 2,
  parameter int CNT_W      = 12
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic             cal_stop,
  input  logic             osc_tick,
  input  logic             inj_req,
  output logic             glob_en,
  output logic [7:0]       delay_con_msb,
  output logic [4:0]       delay_con_lsb,
  output logic [3:0]       con_perb,
  output logic             inj_en,
  output logic             busy,
  output logic             cal_done,
  output logic             locked,
  output logic             cal_err,
  output logic [CNT_W-1:0] last_cnt
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_EVAL    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int TMR_MAX = (WIN_LEN > SETTLE_LEN) ? WIN_LEN : SETTLE_LEN;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_LEN - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [31:0]      TGT32       = 32'(TARGET);
  localparam logic [31:0]      TOL32       = 32'(TOL);

  logic [2:0]       state;
  logic             phase_fine;
  logic [3:0]       coarse;
  logic [2:0]       fine;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      cnt32;
  logic             within_tol;

  logic             eval_done;
  logic             eval_err;
  logic             nxt_phase;
  logic [3:0]       nxt_coarse;
  logic [2:0]       nxt_fine;

  assign cnt_next   = (osc_tick && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
  assign cnt32      = 32'(last_cnt);
  assign within_tol = (cnt32 + TOL32 >= TGT32) && (cnt32 <= TGT32 + TOL32);
  assign busy       = (state == ST_SETTLE) || (state == ST_MEASURE) || (state == ST_EVAL);
  assign con_perb   = 4'd0;

  always_comb begin
    for (int i = 0; i < 8; i++) delay_con_msb[i] = (coarse > 4'(i));
    for (int i = 0; i < 5; i++) delay_con_lsb[i] = (fine > 3'(i));
  end

  // Step decision taken in EVAL from the count just latched into last_cnt
  always_comb begin
    eval_done  = 1'b0;
    eval_err   = 1'b0;
    nxt_phase  = phase_fine;
    nxt_coarse = coarse;
    nxt_fine   = fine;
    if (!phase_fine) begin
      if (cnt32 == TGT32) begin
        eval_done = 1'b1;
      end else if (cnt32 > TGT32) begin
        if (coarse != 4'd8) begin
          nxt_coarse = coarse + 4'd1;
        end else begin
          nxt_phase = 1'b1;
          nxt_fine  = 3'd1;
        end
      end else if (coarse != 4'd0) begin
        nxt_coarse = coarse - 4'd1;
        nxt_phase  = 1'b1;
      end else begin
        eval_done = 1'b1;
        eval_err  = 1'b1;
      end
    end else if (cnt32 > TGT32 && fine != 3'd5) begin
      nxt_fine = fine + 3'd1;
    end else begin
      eval_done = 1'b1;
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase_fine <= 1'b0;
      coarse     <= 4'd0;
      fine       <= 3'd0;
      timer      <= '0;
      cnt        <= '0;
      last_cnt   <= '0;
      glob_en    <= 1'b0;
      inj_en     <= 1'b0;
      cal_done   <= 1'b0;
      locked     <= 1'b0;
      cal_err    <= 1'b0;
    end else begin
      cal_done <= 1'b0;
      if (cal_stop) begin
        state   <= ST_IDLE;
        glob_en <= 1'b0;
        inj_en  <= 1'b0;
        locked  <= 1'b0;
      end else if (cal_start && !busy) begin
        state      <= ST_SETTLE;
        phase_fine <= 1'b0;
        coarse     <= 4'd0;
        fine       <= 3'd0;
        timer      <= '0;
        glob_en    <= 1'b1;
        inj_en     <= 1'b0;
        locked     <= 1'b0;
        cal_err    <= 1'b0;
      end else begin
        inj_en <= locked & inj_req & (state == ST_DONE);
        case (state)
          ST_SETTLE: begin
            if (timer == SETTLE_LAST) begin
              state <= ST_MEASURE;
              timer <= '0;
              cnt   <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_MEASURE: begin
            cnt <= cnt_next;
            if (timer == WIN_LAST) begin
              state    <= ST_EVAL;
              timer    <= '0;
              last_cnt <= cnt_next;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_EVAL: begin
            phase_fine <= nxt_phase;
            coarse     <= nxt_coarse;
            fine       <= nxt_fine;
            timer      <= '0;
            if (eval_done) begin
              state    <= ST_DONE;
              cal_done <= 1'b1;
              locked   <= within_tol;
              cal_err  <= eval_err;
            end else begin
              state <= ST_SETTLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/osc_cal_ctrl.md
OSC_CAL_CTRL -- requirements
Module: osc_cal_ctrl

Interface
REQ-001 SHALL have parameter WIN_LEN, default 256: measurement window length in ref_clk cycles (>=2).
REQ-002 SHALL have parameter SETTLE_LEN, default 16: ref_clk cycles waited after any code change before measuring (>=1).
REQ-003 SHALL have parameter TARGET, default 128: desired osc_tick count per window.
REQ-004 SHALL have parameter TOL, default 2: lock tolerance in counts.
REQ-005 SHALL have parameter CNT_W, default 12: width of the tick counter.
REQ-006 SHALL have port ref_clk, input, 1 bit: the only clock; all state on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port cal_start, input, 1 bit: single-cycle calibration request.
REQ-009 SHALL have port cal_stop, input, 1 bit: abort/disable request.
REQ-010 SHALL have port osc_tick, input, 1 bit: one pulse per divided oscillator period, already synchronous to ref_clk.
REQ-011 SHALL have port inj_req, input, 1 bit: request to enable edge injection.
REQ-012 SHALL have port glob_en, output, 1 bit: ring oscillator enable.
REQ-013 SHALL have port delay_con_msb, output, 8 bits: thermometer coarse code, broadcast to all five stages.
REQ-014 SHALL have port delay_con_lsb, output, 5 bits: thermometer fine code.
REQ-015 SHALL have port con_perb, output, 4 bits: perturbation code, held 0.
REQ-016 SHALL have port inj_en, output, 1 bit: injector enable.
REQ-017 SHALL have port busy, output, 1 bit: calibration in progress.
REQ-018 SHALL have port cal_done, output, 1 bit: one-cycle pulse on entry to DONE.
REQ-019 SHALL have port locked, output, 1 bit: result within tolerance.
REQ-020 SHALL have port cal_err, output, 1 bit: target unreachable.
REQ-021 SHALL have port last_cnt, output, CNT_W bits: count from the most recent window.

Function
REQ-022 SHALL keep internal coarse in 0..8 and fine in 0..5; delay_con_msb has the low coarse bits set, delay_con_lsb has the low fine bits set.
REQ-023 SHALL implement states IDLE, SETTLE, MEASURE, EVAL, DONE, plus a phase flag COARSE/FINE.
REQ-024 IDLE: cal_start -> coarse=0, fine=0, phase=COARSE, glob_en=1, clear locked/cal_err, go to SETTLE.
REQ-025 SETTLE SHALL last exactly SETTLE_LEN cycles, then enter MEASURE with the tick counter cleared.
REQ-026 MEASURE SHALL last exactly WIN_LEN cycles, count every cycle with osc_tick=1 (last cycle included), saturate at 2^CNT_W-1, then enter EVAL and load last_cnt.
REQ-027 EVAL COARSE: cnt==TARGET -> DONE; cnt>TARGET & coarse<8 -> coarse+1, SETTLE; cnt>TARGET & coarse==8 -> phase=FINE, fine=1, SETTLE; cnt<TARGET & coarse>0 -> coarse-1, phase=FINE, SETTLE; cnt<TARGET & coarse==0 -> DONE with cal_err=1.
REQ-028 EVAL FINE: cnt>TARGET & fine<5 -> fine+1, SETTLE; otherwise DONE.
REQ-029 On entering DONE: cal_done high one cycle; locked=1 iff |last_cnt-TARGET|<=TOL; codes held.
REQ-030 busy SHALL be 1 in SETTLE, MEASURE and EVAL, and 0 otherwise.
REQ-031 inj_en SHALL be locked & inj_req & (state==DONE), registered.
REQ-032 cal_start in DONE SHALL restart as from IDLE; cal_start while busy SHALL be ignored.
REQ-033 cal_stop in any state SHALL go to IDLE next cycle with glob_en=0, inj_en=0, locked=0, and codes kept; cal_stop wins over a simultaneous cal_start.
REQ-034 con_perb SHALL be constant 0.

Reset
REQ-035 rst SHALL asynchronously force IDLE with glob_en=0, msb=0, lsb=0, con_perb=0, inj_en=0, busy=0, cal_done=0, locked=0, cal_err=0, last_cnt=0 and counters 0; assertion mid-calibration SHALL abandon the calibration.

Verification
REQ-036 SHALL cover: osc_tick every cycle, cal_start -> last_cnt=256, coarse climbs to 8, fine climbs to 5, DONE, locked=0, msb=8'hFF, lsb=5'h1F.
REQ-037 SHALL cover: tick rate model giving exactly 128 at coarse=3 -> DONE after the 4th window, msb=8'h07, lsb=0, locked=1, cal_err=0.
REQ-038 SHALL cover: no ticks -> one window, cal_err=1, locked=0, msb=0.
REQ-039 SHALL cover: cal_stop asserted in MEASURE together with cal_start -> IDLE, glob_en=0, busy=0.
REQ-040 SHALL cover: rst pulse mid-SETTLE -> all outputs at reset values in the same cycle, and a later cal_start restarts cleanly.
REQ-041 SHALL cover: locked DONE, inj_req=1 -> inj_en=1 one cycle later; cal_start -> inj_en=0 while busy.
